// File: rtl/dmx_pkg.sv
// Shared constants, FSM state type and slot packing helpers for the DMX512 frame builder.
package dmx_pkg;

  localparam int SLOT_BITS    = 11;
  localparam int NUM_SLOTS    = 513;
  localparam int FRAME_BITS   = SLOT_BITS * NUM_SLOTS;
  localparam int NUM_CHANNELS = 512;
  localparam logic [7:0] START_CODE = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FIRE,
    ST_WAIT,
    ST_GAP
  } state_e;

  // Start bit in bit 0, data LSB first, two stop bits on top.
  function automatic logic [SLOT_BITS-1:0] pack_slot(input logic [7:0] data);
    return {2'b11, data, 1'b0};
  endfunction

  function automatic logic [FRAME_BITS-1:0] blank_frame();
    logic [FRAME_BITS-1:0] f;
    f = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      f[k*SLOT_BITS +: SLOT_BITS] = pack_slot(8'h00);
    end
    return f;
  endfunction

endpackage

// File: rtl/dmx_slot_pack.sv
// Combinational packer turning one DMX byte into its 11-bit serial slot.
module dmx_slot_pack
  import dmx_pkg::*;
(
  input  logic [7:0]           data_i,
  output logic [SLOT_BITS-1:0] slot_o
);

  assign slot_o = pack_slot(data_i);

endmodule

// File: rtl/dmx_frame_builder.sv
// Builds a packed DMX512 frame from a 512-byte working buffer and sequences
// load / send / wait / gap handshakes with a downstream serializer.
module dmx_frame_builder
  import dmx_pkg::*;
#(
  parameter int GAP_CYCLES     = 50000,
  parameter int TIMEOUT_CYCLES = 1500000,
  parameter int CONTINUOUS     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [9:0]            wr_addr,
  input  logic [7:0]            wr_data,
  input  logic                  commit,
  input  logic                  tx_done,
  output logic [FRAME_BITS-1:0] frame,
  output logic                  send,
  output logic                  busy,
  output logic                  wr_err,
  output logic [15:0]           frame_count
);

  localparam int CNT_MAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [FRAME_BITS-1:0] BLANK_FRAME = blank_frame();

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    pending_q, pending_d;
  logic [15:0]             fcount_q, fcount_d;
  logic                    tx_prev_q;
  logic                    wr_err_q;
  logic [FRAME_BITS-1:0]   frame_q;
  logic [7:0]              buf_q [NUM_CHANNELS];
  logic [FRAME_BITS-1:0]   packed_w;
  logic                    wr_valid;
  logic [8:0]              wr_idx;
  logic                    tx_rise;

  assign wr_valid = wr_en && (wr_addr != 10'd0) && (wr_addr <= 10'(NUM_CHANNELS));
  assign wr_idx   = 9'(wr_addr - 10'd1);
  assign tx_rise  = tx_done && !tx_prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        buf_q[i] <= '0;
      end
    end else if (wr_valid) begin
      buf_q[wr_idx] <= wr_data;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      logic [7:0] slot_data;
      if (gi == 0) begin : g_start
        assign slot_data = START_CODE;
      end else begin : g_chan
        assign slot_data = buf_q[gi-1];
      end
      dmx_slot_pack u_pack (
        .data_i (slot_data),
        .slot_o (packed_w[gi*SLOT_BITS +: SLOT_BITS])
      );
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    fcount_d  = fcount_q;
    pending_d = pending_q;
    case (state_q)
      ST_IDLE: if (pending_q) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_FIRE;
      ST_FIRE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (tx_rise || (cnt_q == TO_LAST)) begin
          fcount_d = fcount_q + 16'd1;
          state_d  = ST_GAP;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          if (pending_q)            state_d = ST_LOAD;
          else if (CONTINUOUS != 0) state_d = ST_FIRE;
          else                      state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A commit coinciding with LOAD wins, so it survives into the next frame.
    if (state_q == ST_LOAD) pending_d = 1'b0;
    if (commit)             pending_d = 1'b1;
    cnt_d = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      fcount_q  <= '0;
      tx_prev_q <= 1'b0;
      wr_err_q  <= 1'b0;
      frame_q   <= BLANK_FRAME;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      fcount_q  <= fcount_d;
      tx_prev_q <= tx_done;
      wr_err_q  <= wr_en && !wr_valid;
      if (state_q == ST_LOAD) frame_q <= packed_w;
    end
  end

  assign frame       = frame_q;
  assign send        = (state_q == ST_FIRE);
  assign busy        = (state_q != ST_IDLE);
  assign wr_err      = wr_err_q;
  assign frame_count = fcount_q;

endmodule

// File: tb/tb_dmx_frame_builder.sv
// Randomized scoreboard bench for dmx_frame_builder with a slot-level reference model.
module tb_dmx_frame_builder;

  localparam int GAP = 10;
  localparam int TMO = 50;
  localparam int FB  = 5643;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic [9:0]    wr_addr = '0;
  logic [7:0]    wr_data = '0;
  logic          commit = 1'b0;
  logic          tx_done = 1'b0;
  logic [FB-1:0] frame;
  logic          send, busy, wr_err;
  logic [15:0]   frame_count;

  dmx_frame_builder #(
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TMO),
    .CONTINUOUS     (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .commit      (commit),
    .tx_done     (tx_done),
    .frame       (frame),
    .send        (send),
    .busy        (busy),
    .wr_err      (wr_err),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  int            n_cmp = 0;
  int            n_err = 0;
  logic [7:0]    model_buf [512];
  logic [FB-1:0] exp_frames [$];
  int            exp_waits [$];
  logic [FB-1:0] cur_exp = '0;
  bit            running = 1'b0;
  bit            tx_stuck = 1'b0;
  longint        cyc = 0;
  logic          exp_err_q = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Frame as the serial line should carry it: start code, then channels 1..512.
  function automatic logic [FB-1:0] ref_frame();
    logic [FB-1:0] f;
    logic [7:0]    d;
    f = '0;
    for (int k = 0; k < 513; k++) begin
      d = (k == 0) ? 8'h00 : model_buf[k-1];
      f[11*k] = 1'b0;
      for (int b = 0; b < 8; b++) f[11*k+1+b] = d[b];
      f[11*k+9]  = 1'b1;
      f[11*k+10] = 1'b1;
    end
    return f;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_frame(input string name, input logic [FB-1:0] act, input logic [FB-1:0] exp);
    int k;
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      k = 0;
      while (k < 512 && act[11*k +: 11] === exp[11*k +: 11]) k++;
      $display("FAIL %s: slot %0d got %b expected %b", name, k, act[11*k +: 11], exp[11*k +: 11]);
    end
  endtask

  task automatic do_write(input int a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = 10'(a);
    wr_data = d;
    if (a >= 1 && a <= 512) model_buf[a-1] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    exp_frames.push_back(ref_frame());
    @(negedge clk);
    commit = 1'b0;
  endtask

  task automatic wait_send(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (send) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_send: got no send within 300 cycles expected a send");
    end
  endtask

  // Rejected writes must pulse wr_err exactly one cycle later.
  always @(posedge clk) exp_err_q <= wr_en && (wr_addr == 10'd0 || wr_addr > 10'd512);
  always @(negedge clk) begin
    if (running && (exp_err_q || wr_err)) check("wr_err", 64'(wr_err), 64'(exp_err_q));
  end

  // Serializer model: a tx_done pulse D cycles after send, or tx_done held high.
  initial begin : responder
    int d;
    forever begin
      @(negedge clk);
      if (!tx_stuck) tx_done = 1'b0;
      if (running && send) begin
        if (tx_stuck) begin
          tx_done = 1'b1;
          exp_waits.push_back(TMO);
        end else begin
          d = $urandom_range(5, 60);
          exp_waits.push_back(d < TMO ? d : TMO);
          repeat (d) @(negedge clk);
          tx_done = 1'b1;
        end
      end
    end
  end

  initial begin : monitor
    int     nsend;
    longint last;
    bit     loaded;
    int     w;
    nsend = 0;
    last  = 0;
    forever begin
      @(negedge clk);
      if (running && send) begin
        loaded = (exp_frames.size() > 0);
        if (loaded) cur_exp = exp_frames.pop_front();
        check_frame("frame_at_send", frame, cur_exp);
        check("frame_count_at_send", 64'(frame_count), 64'(nsend));
        if (nsend > 0) begin
          if (exp_waits.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL interval_queue: got empty expected a wait length");
          end else begin
            w = exp_waits.pop_front();
            // wait + gap + the FIRE cycle, plus one LOAD cycle when a new frame was published
            check("send_interval", 64'(cyc - last), 64'(w + GAP + 1 + (loaded ? 1 : 0)));
          end
        end
        last = cyc;
        nsend++;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    bit ok;
    int lat;
    int nw;
    bit saw;
    for (int i = 0; i < 512; i++) model_buf[i] = 8'h00;

    repeat (3) @(negedge clk);
    check("reset_send", 64'(send), 0);
    check("reset_busy", 64'(busy), 0);
    check("reset_wr_err", 64'(wr_err), 0);
    check("reset_frame_count", 64'(frame_count), 0);
    check_frame("reset_frame", frame, ref_frame());

    rst = 1'b1;
    running = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_busy", 64'(busy), 0);

    do_write(1, 8'hFF);
    do_write(512, 8'h01);
    do_write(0, 8'h33);
    do_write(600, 8'h44);
    commit = 1'b1;
    exp_frames.push_back(ref_frame());
    lat = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      commit = 1'b0;
      if (send) begin
        lat = n;
        break;
      end
    end
    check("send_latency", 64'(lat), 3);
    check("slot1_ff", 64'(frame[21:11]), 64'(11'b11_11111111_0));
    check("slot512_01", 64'(frame[5642:5632]), 64'(11'b11_00000001_0));
    check("slot0_start", 64'(frame[10:0]), 64'(11'b11_00000000_0));
    check("busy_fire", 64'(busy), 1);

    for (int i = 1; i <= 24; i++) begin
      wait_send(ok);
      if (!ok) break;
      if (i == 4) check("slot5_aa", 64'(frame[65:55]), 64'(11'b11_10101010_0));
      @(negedge clk);
      if (i == 3) begin
        do_write(5, 8'hAA);
        do_commit();
        check_frame("frame_hold_wait", frame, cur_exp);
      end else if ($urandom_range(0, 1) == 1) begin
        nw = $urandom_range(1, 3);
        repeat (nw) do_write($urandom_range(0, 600), 8'($urandom));
        do_commit();
        check_frame("frame_hold", frame, cur_exp);
      end
      if (i == 10) tx_stuck = 1'b1;
      if (i == 13) tx_stuck = 1'b0;
    end

    // Reset in WAIT with a commit pending: everything returns to power-on state.
    wait_send(ok);
    @(negedge clk);
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    @(negedge clk);
    running = 1'b0;
    rst = 1'b0;
    #1;
    for (int i = 0; i < 512; i++) model_buf[i] = 8'h00;
    check("midwait_rst_send", 64'(send), 0);
    check("midwait_rst_busy", 64'(busy), 0);
    check("midwait_rst_frame_count", 64'(frame_count), 0);
    check_frame("midwait_rst_frame", frame, ref_frame());
    @(negedge clk);
    rst = 1'b1;
    saw = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (send || busy) saw = 1'b1;
    end
    check("pending_dropped_by_rst", 64'(saw), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmx_frame_builder.md
DMX_FRAME_BUILDER -- requirements
Module: dmx_frame_builder

Interface
REQ-001 Parameter GAP_CYCLES, 50000, idle cycles between frames (1 ms at 50 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, 1500000, maximum WAIT duration before a frame is forced complete.
REQ-003 Parameter CONTINUOUS, 1, when 1 the last frame is resent after each gap; when 0 a frame is sent only after a commit.
REQ-004 clk  in  1  single system clock, rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 wr_en  in  1  channel write strobe, one write per cycle.
REQ-007 wr_addr  in  10  DMX channel number; valid range 1..512.
REQ-008 wr_data  in  8  channel level.
REQ-009 commit  in  1  single-cycle request to publish the working buffer.
REQ-010 tx_done  in  1  completion flag from the downstream serializer.
REQ-011 frame  out  5643  packed serial frame; bit 0 is transmitted first.
REQ-012 send  out  1  single-cycle start pulse to the serializer.
REQ-013 busy  out  1  high whenever the state is not IDLE.
REQ-014 wr_err  out  1  one-cycle pulse on a rejected write.
REQ-015 frame_count  out  16  number of completed frames; wraps 0xFFFF->0.

Function
REQ-016 The working buffer shall hold 512 bytes; wr_en with wr_addr in 1..512 shall write byte wr_addr-1 at the clock edge.
REQ-017 wr_en with wr_addr of 0 or greater than 512 shall leave the buffer unchanged and pulse wr_err on the next cycle.
REQ-018 Packing: slot k (0..512) shall occupy frame[11k+10:11k], laid out as follows.
- bit 11k = 0 (start bit).
- bits 11k+1..11k+8 = data, LSB first.
- bits 11k+9 and 11k+10 = 1 (two stop bits).
REQ-019 Slot 0 shall carry start code 0x00; slot k for k>=1 shall carry working byte k-1.
REQ-020 commit shall set commit_pending; commit_pending shall be cleared only in LOAD.
- A commit arriving in the same cycle as LOAD shall remain pending.
REQ-021 The FSM shall have the states IDLE, LOAD, FIRE, WAIT and GAP.
REQ-022 IDLE: go to LOAD when commit_pending is set.
REQ-023 LOAD: frame shall capture the packed working buffer; next state is FIRE.
- A write in the same cycle shall not appear in the captured frame (pre-write value captured).
REQ-024 FIRE: send=1 for exactly this one cycle; next state is WAIT.
REQ-025 WAIT: on a tx_done rising edge (registered previous value) or when the wait counter reaches TIMEOUT_CYCLES-1, whichever comes first:
- increment frame_count;
- go to GAP.
REQ-026 tx_done edges outside WAIT shall be ignored; a tx_done held high produces no edge, so the timeout ends the frame.
REQ-027 GAP: count GAP_CYCLES cycles, then choose the next state in this priority:
- LOAD if commit_pending is set;
- FIRE if CONTINUOUS=1;
- otherwise IDLE.
REQ-028 frame shall be stable from LOAD exit until the next LOAD; writes shall never alter frame directly.
REQ-029 Counter widths shall be at least ceil(log2(TIMEOUT_CYCLES)); the counter shall clear on every state entry.

Reset
REQ-030 On rst low, asynchronously:
- state=IDLE; send=0; busy=0; wr_err=0;
- frame_count=0; commit_pending=0;
- working buffer all 0x00; previous tx_done=0;
- frame=packed all-zero buffer (every slot 0b11_00000000_0).
REQ-031 Reset mid-frame shall drop send at once and discard any pending commit.

Structure
REQ-032 Shared package dmx_pkg shall hold the following:
- SLOT_BITS=11, NUM_SLOTS=513, FRAME_BITS=5643, NUM_CHANNELS=512;
- START_CODE=8'h00;
- the FSM state enumeration.
REQ-033 Sub-module dmx_slot_pack (8-bit in, 11-bit out, combinational) shall be instantiated once per slot by a generate loop.

Verification
REQ-034 Write ch1=0xFF, ch512=0x01, commit -> one send pulse 3 cycles after commit, with the following frame contents:
- frame[21:11]=11'b11_11111111_0;
- frame[5642:5632]=11'b11_00000001_0;
- frame[10:0]=11'b11_00000000_0.
REQ-035 Write to addr 0 and to addr 600 -> wr_err pulses twice; frame and buffer unchanged.
REQ-036 CONTINUOUS=1, GAP_CYCLES=10, tx_done pulsed 100 cycles after each send -> sends spaced 111 cycles apart; frame_count increments once per frame.
REQ-037 tx_done stuck high, TIMEOUT_CYCLES=50 -> WAIT lasts 50 cycles, then GAP; frame_count increments.
REQ-038 Commit and a write to ch5=0xAA during WAIT -> the current frame is unchanged and the next LOAD frame has slot 5 data 0xAA.
REQ-039 rst low during WAIT -> send=0, busy=0, frame_count=0, frame restored to the all-zero packing.
